// File: rtl/fifo_level_pkg.sv
// fifo_level_pkg -- shared defaults and flag helpers for the level-reporting FIFO.
//   Default geometry (B/W) and threshold levels used by the UART and PS/2 FIFO
//   instances, plus the flag bundle and the function that derives it from an
//   occupancy count. The count output is W+1 bits wide so it can hold 0..2**W.
package fifo_level_pkg;

  localparam int FIFO_B_DEF  = 8;   // data word width
  localparam int FIFO_W_DEF  = 4;   // address bits, depth = 2**W
  localparam int FIFO_AF_DEF = 12;  // almost_full when count >= this
  localparam int FIFO_AE_DEF = 2;   // almost_empty when count <= this

  typedef struct packed {
    logic empty;
    logic full;
    logic almost_empty;
    logic almost_full;
  } fifo_flags_t;

  // All level flags come from one count value so they can never disagree.
  function automatic fifo_flags_t level_flags(input int cnt, input int depth,
                                              input int af, input int ae);
    fifo_flags_t f;
    f.empty        = (cnt == 0);
    f.full         = (cnt == depth);
    f.almost_empty = (cnt <= ae);
    f.almost_full  = (cnt >= af);
    return f;
  endfunction

endpackage

// File: rtl/fifo_ram.sv
// fifo_ram -- 2**W x B register file, synchronous write, asynchronous read.
//   clk     in  write clock, rising edge
//   we      in  write enable
//   w_addr  in  W-bit write address
//   w_data  in  B-bit write word
//   r_addr  in  W-bit read address
//   r_data  out B-bit word at r_addr (combinational)
// Storage is deliberately not reset.
module fifo_ram #(
  parameter int B = 8,
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         we,
  input  logic [W-1:0] w_addr,
  input  logic [B-1:0] w_data,
  input  logic [W-1:0] r_addr,
  output logic [B-1:0] r_data
);

  logic [B-1:0] mem [2**W];

  always_ff @(posedge clk)
    if (we) mem[w_addr] <= w_data;

  assign r_data = mem[r_addr];

endmodule

// File: rtl/fifo_level.sv
// fifo_level -- synchronous FIFO with occupancy count and almost-full/empty.
//   clk, reset          clock (rising edge), asynchronous active-high reset
//   rd, wr              pop / push requests (ignored when empty / full)
//   w_data              word to push
//   clr_err             clears sticky overflow/underflow
//   r_data              head-of-queue word, combinational from read pointer
//   empty, full         registered, from count
//   almost_empty/full   registered, count <= AE_LEVEL / count >= AF_LEVEL
//   count               registered occupancy 0..2**W
//   overflow/underflow  sticky error flags
// Build option: define FIFO_ERR_FLAGS_EN to get the sticky error flags;
// otherwise overflow/underflow are constant 0 and clr_err is ignored.
module fifo_level
  import fifo_level_pkg::*;
#(
  parameter int B        = FIFO_B_DEF,
  parameter int W        = FIFO_W_DEF,
  parameter int AF_LEVEL = FIFO_AF_DEF,
  parameter int AE_LEVEL = FIFO_AE_DEF
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         rd,
  input  logic         wr,
  input  logic [B-1:0] w_data,
  input  logic         clr_err,
  output logic [B-1:0] r_data,
  output logic         empty,
  output logic         full,
  output logic         almost_empty,
  output logic         almost_full,
  output logic [W:0]   count,
  output logic         overflow,
  output logic         underflow
);

  localparam int DEPTH = 1 << W;
  localparam fifo_flags_t RST_FLAGS = level_flags(0, DEPTH, AF_LEVEL, AE_LEVEL);

  logic [W-1:0] w_ptr, r_ptr;
  logic         rd_ok, wr_ok;
  logic [W:0]   count_next;
  fifo_flags_t  flags, flags_next;

  // Qualify against registered flags; full/empty come from count, so
  // pointers may wrap freely without needing an extra lap bit.
  assign rd_ok = rd & ~flags.empty;
  assign wr_ok = wr & ~flags.full;

  always_comb begin
    count_next = count;
    if (wr_ok && !rd_ok)      count_next = count + (W+1)'(1);
    else if (rd_ok && !wr_ok) count_next = count - (W+1)'(1);
  end

  assign flags_next = level_flags(int'(count_next), DEPTH, AF_LEVEL, AE_LEVEL);

  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      w_ptr <= '0;
      r_ptr <= '0;
      count <= '0;
      flags <= RST_FLAGS;
    end else begin
      if (wr_ok) w_ptr <= w_ptr + W'(1);
      if (rd_ok) r_ptr <= r_ptr + W'(1);
      count <= count_next;
      flags <= flags_next;
    end

  assign empty        = flags.empty;
  assign full         = flags.full;
  assign almost_empty = flags.almost_empty;
  assign almost_full  = flags.almost_full;

  fifo_ram #(.B(B), .W(W)) u_ram (
    .clk    (clk),
    .we     (wr_ok),
    .w_addr (w_ptr),
    .w_data (w_data),
    .r_addr (r_ptr),
    .r_data (r_data)
  );

`ifdef FIFO_ERR_FLAGS_EN
  // Clear has priority over a same-cycle set.
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else if (clr_err) begin
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (wr && flags.full)  overflow  <= 1'b1;
      if (rd && flags.empty) underflow <= 1'b1;
    end
`else
  logic clr_err_unused;
  assign clr_err_unused = clr_err;
  assign overflow  = 1'b0;
  assign underflow = 1'b0;
`endif

endmodule

// File: tb/tb_fifo_level.sv
module tb_fifo_level;

  localparam int B = 8;
  localparam int W = 4;
  localparam int DEPTH = 16;
  localparam int AF = 12;
  localparam int AE = 2;
`ifdef FIFO_ERR_FLAGS_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         rd = 1'b0, wr = 1'b0, clr_err = 1'b0;
  logic [B-1:0] w_data = '0;
  logic [B-1:0] r_data;
  logic         empty, full, almost_empty, almost_full, overflow, underflow;
  logic [W:0]   count;

  fifo_level #(.B(B), .W(W), .AF_LEVEL(AF), .AE_LEVEL(AE)) dut (
    .clk(clk), .reset(reset), .rd(rd), .wr(wr), .w_data(w_data),
    .clr_err(clr_err), .r_data(r_data), .empty(empty), .full(full),
    .almost_empty(almost_empty), .almost_full(almost_full), .count(count),
    .overflow(overflow), .underflow(underflow)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: a plain queue plus sticky error bits.
  logic [B-1:0] q[$];
  bit ovf_m, unf_m;

  function automatic logic [10:0] exp_vec();
    int n = q.size();
    return {5'(n), n == 0, n == DEPTH, n <= AE, n >= AF, ovf_m, unf_m};
  endfunction

  logic [10:0] obs_vec;
  assign obs_vec = {count, empty, full, almost_empty, almost_full, overflow, underflow};

  function automatic void model_reset();
    q.delete();
    ovf_m = 0;
    unf_m = 0;
  endfunction

  // One clock with the given requests; inputs change 1ns after the edge and
  // outputs are sampled 1ns after the next edge.
  task automatic step(input bit w, input bit r, input logic [B-1:0] d, input bit c = 0);
    bit was_empty, was_full;
    wr = w; rd = r; w_data = d; clr_err = c;
    @(posedge clk);
    was_empty = (q.size() == 0);
    was_full  = (q.size() == DEPTH);
    if (ERR_EN) begin
      if (c) begin ovf_m = 0; unf_m = 0; end
      else begin
        if (w && was_full)  ovf_m = 1;
        if (r && was_empty) unf_m = 1;
      end
    end
    if (r && !was_empty) void'(q.pop_front());
    if (w && !was_full)  q.push_back(d);
    #1;
    wr = 0; rd = 0; clr_err = 0;
  endtask

  task automatic test_reset();
    reset = 1;
    model_reset();
    #12;
    n_cmp++;
    if (obs_vec !== exp_vec()) begin
      n_bad++; $display("FAIL reset_hold: got %b want %b", obs_vec, exp_vec());
    end
    @(posedge clk); #1; reset = 0;
    repeat (3) step(0, 0, '0);
    n_cmp++;
    if (obs_vec !== exp_vec()) begin
      n_bad++; $display("FAIL reset_idle: got %b want %b", obs_vec, exp_vec());
    end
  endtask

  task automatic test_fill();
    for (int i = 0; i < DEPTH + 1; i++) begin
      step(1, 0, B'(i));
      n_cmp++;
      if (obs_vec !== exp_vec()) begin
        n_bad++; $display("FAIL fill[%0d]: got %b want %b", i, obs_vec, exp_vec());
      end
    end
    n_cmp++;
    if (full !== 1'b1 || count !== 5'd16) begin
      n_bad++; $display("FAIL fill_full: full=%b count=%0d want 1/16", full, count);
    end
  endtask

  task automatic test_drain();
    for (int i = 0; i < DEPTH; i++) begin
      n_cmp++;
      if (r_data !== B'(i)) begin
        n_bad++; $display("FAIL drain_data[%0d]: got %h want %h", i, r_data, B'(i));
      end
      step(0, 1, '0);
      n_cmp++;
      if (obs_vec !== exp_vec()) begin
        n_bad++; $display("FAIL drain[%0d]: got %b want %b", i, obs_vec, exp_vec());
      end
    end
    step(0, 1, '0);
    n_cmp++;
    if (obs_vec !== exp_vec() || underflow !== ERR_EN) begin
      n_bad++; $display("FAIL extra_pop: got %b want %b", obs_vec, exp_vec());
    end
    step(0, 0, '0, 1);
    n_cmp++;
    if (overflow !== 1'b0 || underflow !== 1'b0) begin
      n_bad++; $display("FAIL clr_err: ovf=%b unf=%b want 0/0", overflow, underflow);
    end
  endtask

  task automatic test_wrap();
    logic [B-1:0] d;
    for (int i = 0; i < 10; i++) step(1, 0, B'($urandom));
    for (int i = 0; i < 10; i++) step(0, 1, '0);
    for (int i = 0; i < 10; i++) step(1, 0, B'($urandom));
    for (int i = 0; i < 10; i++) begin
      d = q[0];
      n_cmp++;
      if (r_data !== d) begin
        n_bad++; $display("FAIL wrap_data[%0d]: got %h want %h", i, r_data, d);
      end
      step(0, 1, '0);
    end
    n_cmp++;
    if (obs_vec !== exp_vec()) begin
      n_bad++; $display("FAIL wrap_end: got %b want %b", obs_vec, exp_vec());
    end
  endtask

  task automatic test_simul();
    for (int i = 0; i < 5; i++) step(1, 0, B'($urandom));
    step(1, 1, 8'hA5);
    n_cmp++;
    if (count !== 5'd5 || obs_vec !== exp_vec()) begin
      n_bad++; $display("FAIL simul_mid: got %b want %b", obs_vec, exp_vec());
    end
    while (q.size() > 0) step(0, 1, '0);
    step(1, 1, 8'h3C);
    n_cmp++;
    if (count !== 5'd1 || underflow !== ERR_EN || r_data !== 8'h3C) begin
      n_bad++; $display("FAIL simul_empty: count=%0d unf=%b data=%h want 1/%b/3c",
                        count, underflow, r_data, ERR_EN);
    end
    step(0, 0, '0, 1);
    while (q.size() < DEPTH) step(1, 0, B'($urandom));
    step(1, 1, 8'h77);
    n_cmp++;
    if (count !== 5'd15 || overflow !== ERR_EN || obs_vec !== exp_vec()) begin
      n_bad++; $display("FAIL simul_full: got %b want %b", obs_vec, exp_vec());
    end
  endtask

  task automatic test_async_reset();
    while (q.size() > 7) step(0, 1, '0);
    n_cmp++;
    if (count !== 5'd7) begin
      n_bad++; $display("FAIL pre_reset_count: got %0d want 7", count);
    end
    #3;
    reset = 1;
    model_reset();
    #1;
    n_cmp++;
    if (obs_vec !== exp_vec()) begin
      n_bad++; $display("FAIL async_reset: got %b want %b", obs_vec, exp_vec());
    end
    @(posedge clk); #1; reset = 0;
    step(1, 0, 8'hC3);
    n_cmp++;
    if (r_data !== 8'hC3 || obs_vec !== exp_vec()) begin
      n_bad++; $display("FAIL post_reset_push: data=%h vec=%b want c3 %b", r_data, obs_vec, exp_vec());
    end
  endtask

  task automatic test_random();
    logic [B-1:0] d;
    for (int i = 0; i < 400; i++) begin
      // Bias push/pop rate by phase so the level sweeps both ends.
      bit w = ($urandom_range(0, 99) < ((i / 50) % 2 ? 30 : 70));
      bit r = ($urandom_range(0, 99) < ((i / 50) % 2 ? 70 : 30));
      bit c = ($urandom_range(0, 99) < 5);
      step(w, r, B'($urandom), c);
      n_cmp++;
      if (obs_vec !== exp_vec()) begin
        n_bad++; $display("FAIL rand_flags[%0d]: got %b want %b", i, obs_vec, exp_vec());
      end
      if (q.size() > 0) begin
        d = q[0];
        n_cmp++;
        if (r_data !== d) begin
          n_bad++; $display("FAIL rand_data[%0d]: got %h want %h", i, r_data, d);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_fill();
    test_drain();
    test_wrap();
    test_simul();
    test_async_reset();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
